// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StLaunch = 2'b01,
        StDrain  = 2'b10,
        StGap    = 2'b11
    } tx_state_e;

    localparam int unsigned DefClkDiv = 5208;
    localparam int unsigned DefDataW  = 7;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud enable: tick_o is high for one cycle every CLK_DIV cycles.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    // The tick is registered from the next count so it lines up with cnt_q == CntMax.
    always_comb begin
        cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        tick_d = (cnt_d == CntMax);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between NUM_REQ character sources.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned CLK_DIV   = DefClkDiv,
    parameter int unsigned GAP_TICKS = 1,
    parameter int unsigned LAUNCH_TO = 16,
    localparam int unsigned IdW      = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      tx_start_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_busy_i,
    output logic                      tx_en_o,
    output logic [IdW-1:0]            grant_id_o,
    output logic                      active_o,
    output logic                      launch_err_o
);

    localparam int unsigned LaunchW = (LAUNCH_TO > 1) ? $clog2(LAUNCH_TO) : 1;
    localparam int unsigned GapW    = $clog2(GAP_TICKS + 2);

    tx_state_e            state_q, state_d;
    logic [IdW-1:0]       ptr_q, ptr_d;
    logic [IdW-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;
    logic                 err_q, err_d;
    logic [LaunchW-1:0]   lcnt_q, lcnt_d;
    logic [GapW-1:0]      gcnt_q, gcnt_d;
    logic [IdW-1:0]       winner;

    // Scan from the farthest position back to ptr so the nearest valid requester wins.
    function automatic logic [IdW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IdW-1:0]     ptr);
        logic [IdW-1:0] pick;
        int             idx;
        pick = ptr;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % int'(NUM_REQ);
            if (valid[idx]) pick = IdW'(idx);
        end
        return pick;
    endfunction

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_tick (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .tick_o (tx_en_o)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        req_ready_d = '0;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        err_d       = 1'b0;
        lcnt_d      = lcnt_q;
        gcnt_d      = gcnt_q;
        winner      = rr_pick(req_valid_i, ptr_q);

        unique case (state_q)
            StIdle: begin
                if (|req_valid_i) begin
                    state_d             = StLaunch;
                    grant_d             = winner;
                    tx_data_d           = req_data_i[32'(winner) * DATA_W +: DATA_W];
                    req_ready_d[winner] = 1'b1;
                    tx_start_d          = 1'b1;
                    lcnt_d              = '0;
                end
            end
            StLaunch: begin
                if (tx_busy_i) begin
                    state_d    = StDrain;
                    tx_start_d = 1'b0;
                end else if (lcnt_q == LaunchW'(LAUNCH_TO - 1)) begin
                    // Character is dropped; ptr stays so the same source wins again.
                    state_d    = StIdle;
                    tx_start_d = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + LaunchW'(1);
                end
            end
            StDrain: begin
                if (!tx_busy_i) begin
                    state_d = StGap;
                    ptr_d   = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + IdW'(1);
                    gcnt_d  = '0;
                end
            end
            StGap: begin
                if (GAP_TICKS == 0) begin
                    state_d = StIdle;
                end else if (tx_en_o) begin
                    if (gcnt_q == GapW'(GAP_TICKS - 1)) state_d = StIdle;
                    else                                gcnt_d  = gcnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            grant_q     <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            err_q       <= 1'b0;
            lcnt_q      <= '0;
            gcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
            lcnt_q      <= lcnt_d;
            gcnt_q      <= gcnt_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign tx_start_o   = tx_start_q;
    assign tx_data_o    = tx_data_q;
    assign grant_id_o   = grant_q;
    assign launch_err_o = err_q;
    assign active_o     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized scoreboard bench for uart_tx_scheduler with a behavioural transmitter.
module tb_uart_tx_scheduler;

    localparam int unsigned NReq     = 4;
    localparam int unsigned DataW    = 7;
    localparam int unsigned ClkDiv   = 4;
    localparam int unsigned GapTicks = 1;
    localparam int unsigned LaunchTo = 16;
    localparam int          NRand    = 25;

    logic             clk;
    logic             reset;
    logic [NReq-1:0]  req_valid;
    logic [NReq*DataW-1:0] req_data;
    logic [NReq-1:0]  req_ready;
    logic             tx_start;
    logic [DataW-1:0] tx_data;
    logic             tx_busy;
    logic             tx_en;
    logic [1:0]       grant_id;
    logic             active;
    logic             launch_err;

    int checks = 0;
    int errors = 0;

    logic             vld [NReq];
    logic [DataW-1:0] dat [NReq];
    int               ptr_m;
    int               last_w;
    logic [8:0]       exp_q [$];
    bit               nobusy = 1'b0;

    uart_tx_scheduler #(
        .NUM_REQ  (NReq),
        .DATA_W   (DataW),
        .CLK_DIV  (ClkDiv),
        .GAP_TICKS(GapTicks),
        .LAUNCH_TO(LaunchTo)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .tx_busy_i   (tx_busy),
        .tx_en_o     (tx_en),
        .grant_id_o  (grant_id),
        .active_o    (active),
        .launch_err_o(launch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic apply();
        for (int i = 0; i < int'(NReq); i++) begin
            req_valid[i]                 = vld[i];
            req_data[i*DataW +: DataW]   = dat[i];
        end
    endtask

    // Reference arbitration: first valid requester at or after ptr, wrapping.
    function automatic int pick();
        int idx;
        for (int k = 0; k < int'(NReq); k++) begin
            idx = (ptr_m + k) % int'(NReq);
            if (vld[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic push_pick();
        int w;
        w = pick();
        if (w >= 0) begin
            last_w = w;
            exp_q.push_back({2'(w), dat[w]});
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (req_ready == '0 && n < 300);
        if (req_ready == '0) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: no grant within %0d cycles, expected one", n);
            finish_now();
        end
    endtask

    task automatic update_slots();
        if ($urandom_range(0, 1) == 1) dat[last_w] = DataW'($urandom);
        else                           vld[last_w] = 1'b0;
        for (int i = 0; i < int'(NReq); i++) begin
            if (i != last_w) begin
                if (!vld[i] && $urandom_range(0, 9) < 3) begin
                    vld[i] = 1'b1;
                    dat[i] = DataW'($urandom);
                end else if (vld[i] && $urandom_range(0, 9) == 0) begin
                    vld[i] = 1'b0;
                end
            end
        end
    endtask

    // Transmitter model: busy rises one cycle after start is seen, lasts 1..6 cycles.
    initial begin : tx_model
        int cnt;
        bit pend;
        tx_busy = 1'b0;
        pend    = 1'b0;
        cnt     = 0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                tx_busy = 1'b0;
                pend    = 1'b0;
            end else if (pend) begin
                tx_busy = 1'b1;
                cnt     = $urandom_range(1, 6);
                pend    = 1'b0;
            end else if (tx_busy) begin
                cnt--;
                if (cnt == 0) tx_busy = 1'b0;
            end else if (tx_start && !nobusy) begin
                pend = 1'b1;
            end
        end
    end

    initial begin : monitor
        int         k;
        int         run;
        logic [DataW-1:0] last_data;
        logic [8:0] e;
        k         = 0;
        run       = 0;
        last_data = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                k         = 0;
                run       = 0;
                last_data = '0;
                chk("rst_tx_en", int'(tx_en), 0);
                chk("rst_tx_start", int'(tx_start), 0);
                chk("rst_active", int'(active), 0);
                chk("rst_grant_id", int'(grant_id), 0);
                chk("rst_req_ready", int'(req_ready), 0);
                chk("rst_tx_data", int'(tx_data), 0);
                chk("rst_launch_err", int'(launch_err), 0);
            end else begin
                k++;
                chk("tx_en_period", int'(tx_en), int'((k % int'(ClkDiv)) == int'(ClkDiv) - 1));
                if (req_ready != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: req_ready=%b, expected no grant", req_ready);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ready_onehot", int'(req_ready), 1 << e[8:7]);
                        chk("grant_id", int'(grant_id), int'(e[8:7]));
                        chk("tx_data", int'(tx_data), int'(e[6:0]));
                        chk("tx_start_rise", int'(tx_start), 1);
                        chk("active_launch", int'(active), 1);
                    end
                end else begin
                    chk("tx_data_stable", int'(tx_data), int'(last_data));
                end
                last_data = tx_data;
                if (tx_start) begin
                    run++;
                end else if (run > 0) begin
                    chk("tx_start_len", run, nobusy ? int'(LaunchTo) : 2);
                    chk("launch_err_pulse", int'(launch_err), int'(nobusy));
                    run = 0;
                end else begin
                    chk("launch_err_idle", int'(launch_err), 0);
                end
            end
        end
    end

    initial begin : driver
        int  n;
        bit  prev;
        bit  any;
        reset = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < int'(NReq); i++) begin
            vld[i] = 1'b0;
            dat[i] = '0;
        end
        apply();
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        // All requesters valid, then only 0 and 3 after 3 is served.
        for (int i = 0; i < int'(NReq); i++) begin
            vld[i] = 1'b1;
            dat[i] = DataW'($urandom);
        end
        apply();
        push_pick();
        for (int g = 0; g < int'(NReq); g++) begin
            wait_ready();
            ptr_m = (last_w + 1) % int'(NReq);
            if (g == int'(NReq) - 1) begin
                vld[1] = 1'b0;
                vld[2] = 1'b0;
                dat[3] = DataW'($urandom);
            end else begin
                dat[last_w] = DataW'($urandom);
            end
            apply();
            push_pick();
        end
        wait_ready();
        ptr_m = (last_w + 1) % int'(NReq);
        for (int i = 0; i < int'(NReq); i++) vld[i] = 1'b0;
        apply();

        // Single request from source 2 and the active window around the gap.
        vld[2] = 1'b1;
        dat[2] = 7'h41;
        apply();
        push_pick();
        wait_ready();
        ptr_m  = (last_w + 1) % int'(NReq);
        vld[2] = 1'b0;
        apply();
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!tx_busy && n < 20);
        chk("busy_seen", int'(tx_busy), 1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (tx_busy && n < 20);
        chk("busy_fall_seen", int'(tx_busy), 0);
        chk("active_gap_start", int'(active), 1);
        prev = tx_en;
        for (int c = 0; c < 2 * int'(ClkDiv) && !prev; c++) begin
            @(posedge clk); #1;
            chk("active_in_gap", int'(active), 1);
            prev = tx_en;
        end
        @(posedge clk); #1;
        chk("active_after_gap", int'(active), 0);

        // Transmitter never answers: timeout, then the same source is granted again.
        nobusy = 1'b1;
        vld[1] = 1'b1;
        dat[1] = DataW'($urandom);
        vld[2] = 1'b1;
        dat[2] = DataW'($urandom);
        apply();
        push_pick();
        wait_ready();
        dat[1] = DataW'($urandom);
        apply();
        push_pick();
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!launch_err && n < 40);
        chk("launch_err_delay", n, int'(LaunchTo));
        wait_ready();
        for (int i = 0; i < int'(NReq); i++) vld[i] = 1'b0;
        apply();
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!launch_err && n < 40);
        chk("launch_err_second", int'(launch_err), 1);
        @(posedge clk); #1;
        nobusy = 1'b0;

        // Reset while the scheduler is draining a frame.
        vld[0] = 1'b1;
        dat[0] = DataW'($urandom);
        apply();
        push_pick();
        wait_ready();
        vld[0] = 1'b0;
        apply();
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!tx_busy && n < 20);
        chk("drain_busy_seen", int'(tx_busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx_start", int'(tx_start), 0);
        chk("async_rst_active", int'(active), 0);
        chk("async_rst_grant_id", int'(grant_id), 0);
        chk("async_rst_tx_en", int'(tx_en), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        ptr_m = 0;

        // Randomized traffic.
        for (int t = 0; t < NRand; t++) begin
            any = 1'b0;
            for (int i = 0; i < int'(NReq); i++) any |= vld[i];
            if (!any) begin
                n      = $urandom_range(0, int'(NReq) - 1);
                vld[n] = 1'b1;
                dat[n] = DataW'($urandom);
            end
            apply();
            push_pick();
            wait_ready();
            ptr_m = (last_w + 1) % int'(NReq);
            update_slots();
        end
        for (int i = 0; i < int'(NReq); i++) vld[i] = 1'b0;
        apply();
        repeat (40) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        finish_now();
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, expected the run to finish");
        $fatal(1);
    end

endmodule
